// File: rtl/imem_loader_if.sv
// Byte-serial program stream into the instruction memory loader.
// The host drives valid/byte/last; the loader answers with ready.
interface imem_loader_if;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_last;
    logic       ld_ready;

    modport master (output ld_valid, output ld_byte, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_byte, input ld_last, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// 256x16 instruction memory with a clear-then-load FSM that keeps the CPU disabled
// until a complete, error-free program is resident.
module imem_loader #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_datain,
    input  logic          ld_start,
    imem_loader_if.slave  ld,
    output logic          cpu_enable,
    output logic          ld_busy,
    output logic [AW:0]   ld_count,
    output logic          ld_err
);

    typedef enum logic [2:0] {IDLE, CLEAR, RECV_HI, RECV_LO, DONE} state_t;

    localparam logic [AW:0] W_FULL = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic [7:0]    r_hi;
    logic          r_ready;
    logic          r_busy;
    logic          r_cpu_en;
    logic          r_err;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_mem [0:(2**AW)-1];

    logic          w_hs;
    logic          w_ovf;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    assign w_hs  = ld.ld_valid & r_ready;
    assign w_ovf = (r_count == W_FULL);

    // One write port shared by the clear sweep and the word assembler.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (r_state == RECV_LO && w_hs && !w_ovf) begin
            w_we    = 1'b1;
            w_waddr = r_count[AW-1:0];
            w_wdata = {r_hi, ld.ld_byte};
        end
    end

    always_ff @(posedge clock) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Bubble words while loading so the CPU never fetches a half-written program.
    assign i_datain = r_busy ? '0 : r_mem[i_addr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
            r_hi       <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_cpu_en   <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (ld_start) begin
                        r_state    <= CLEAR;
                        r_cpu_en   <= 1'b0;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == '1) begin
                        r_state <= RECV_HI;
                        r_ready <= 1'b1;
                    end
                end
                RECV_HI: begin
                    if (w_hs) begin
                        if (ld.ld_last) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hi    <= ld.ld_byte;
                            r_state <= RECV_LO;
                        end
                    end
                end
                RECV_LO: begin
                    if (w_hs) begin
                        if (w_ovf)
                            r_err <= 1'b1;
                        else
                            r_count <= r_count + 1'b1;
                        if (ld.ld_last) begin
                            r_state  <= DONE;
                            r_ready  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_cpu_en <= !(r_err || w_ovf);
                        end else begin
                            r_state <= RECV_HI;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ld.ld_ready = r_ready;
    assign ld_busy     = r_busy;
    assign cpu_enable  = r_cpu_en;
    assign ld_count    = r_count;
    assign ld_err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, clear timing, normal/odd/overflow loads,
// reload and mid-load reset, each compared against hand-computed values.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic        ld_start;
    logic        cpu_enable;
    logic        ld_busy;
    logic [8:0]  ld_count;
    logic        ld_err;

    int checks   = 0;
    int failures = 0;

    imem_loader_if ldif ();

    imem_loader #(.AW(8), .DW(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_addr     (i_addr),
        .i_datain   (i_datain),
        .ld_start   (ld_start),
        .ld         (ldif),
        .cpu_enable (cpu_enable),
        .ld_busy    (ld_busy),
        .ld_count   (ld_count),
        .ld_err     (ld_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        @(posedge clock); #1;
        ld_start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ldif.ld_ready !== 1'b1 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        check("wait_ready", 32'(ldif.ld_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        ldif.ld_valid = 1'b1;
        ldif.ld_byte  = b;
        ldif.ld_last  = last;
        while (ldif.ld_ready !== 1'b1 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        check("send_ready", 32'(ldif.ld_ready), 32'd1);
        @(posedge clock); #1;
        ldif.ld_valid = 1'b0;
        ldif.ld_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic read_mem(input logic [7:0] a, input logic [15:0] exp, input string tag);
        i_addr = a;
        #1;
        check(tag, 32'(i_datain), 32'(exp));
    endtask

    initial begin
        int bad;
        logic [8:0] kk;

        reset         = 1'b0;
        ld_start      = 1'b0;
        ldif.ld_valid = 1'b0;
        ldif.ld_byte  = 8'h00;
        ldif.ld_last  = 1'b0;
        i_addr        = 8'h00;

        #12;
        check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        check("rst_ld_ready", 32'(ldif.ld_ready), 32'd0);
        check("rst_ld_busy", 32'(ld_busy), 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Clear window: busy with ready low for exactly 256 cycles, bubbles on the read port
        i_addr = 8'h05;
        start_load();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (ldif.ld_ready !== 1'b0 || ld_busy !== 1'b1 || i_datain !== 16'h0000)
                bad++;
            @(posedge clock); #1;
        end
        check("clear_window_bad_cycles", 32'(bad), 32'd0);
        check("clear_end_ready", 32'(ldif.ld_ready), 32'd1);

        // Normal two-word load with valid gaps
        send(8'h12, 1'b0); idle(2);
        send(8'h34, 1'b0); idle(1);
        send(8'hAB, 1'b0); idle(3);
        send(8'hCD, 1'b1);
        check("norm_count", 32'(ld_count), 32'd2);
        check("norm_err", 32'(ld_err), 32'd0);
        check("norm_cpu_enable", 32'(cpu_enable), 32'd1);
        check("norm_busy", 32'(ld_busy), 32'd0);
        check("norm_ready", 32'(ldif.ld_ready), 32'd0);
        read_mem(8'h00, 16'h1234, "norm_mem0");
        read_mem(8'h01, 16'hABCD, "norm_mem1");

        // Asynchronous reset mid-cycle; memory survives
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check("async_cpu_enable", 32'(cpu_enable), 32'd0);
        check("async_count", 32'(ld_count), 32'd0);
        check("async_err", 32'(ld_err), 32'd0);
        check("async_ready", 32'(ldif.ld_ready), 32'd0);
        check("async_busy", 32'(ld_busy), 32'd0);
        #2;
        reset = 1'b1;
        read_mem(8'h01, 16'hABCD, "mem_kept_after_reset");
        idle(5);
        check("idle_cpu_enable", 32'(cpu_enable), 32'd0);

        // Valid in IDLE is not consumed
        ldif.ld_valid = 1'b1;
        ldif.ld_byte  = 8'hEE;
        idle(3);
        check("idle_valid_ready", 32'(ldif.ld_ready), 32'd0);
        check("idle_valid_busy", 32'(ld_busy), 32'd0);
        ldif.ld_valid = 1'b0;

        // One-word load; clear must have wiped the rest of memory
        start_load();
        wait_ready();
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b1);
        check("one_count", 32'(ld_count), 32'd1);
        check("one_cpu_enable", 32'(cpu_enable), 32'd1);
        read_mem(8'h00, 16'h5AA5, "one_mem0");
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            i_addr = 8'(i);
            #1;
            if (i_datain !== 16'h0000) bad++;
        end
        check("one_mem_rest_nonzero", 32'(bad), 32'd0);

        // Reload from DONE drops cpu_enable on the accepting edge
        start_load();
        check("reload_cpu_enable", 32'(cpu_enable), 32'd0);
        check("reload_busy", 32'(ld_busy), 32'd1);
        wait_ready();

        // Odd byte count
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b1);
        check("odd_count", 32'(ld_count), 32'd1);
        check("odd_err", 32'(ld_err), 32'd1);
        check("odd_cpu_enable", 32'(cpu_enable), 32'd0);
        check("odd_busy", 32'(ld_busy), 32'd0);
        read_mem(8'h00, 16'h1234, "odd_mem0");

        // Overflow: 257 words, word k = {k[7:0], 8'h3C ^ k[8]}
        start_load();
        wait_ready();
        for (int k = 0; k < 257; k++) begin
            kk = 9'(k);
            send(kk[7:0], 1'b0);
            send(8'h3C ^ {7'b0, kk[8]}, (k == 256));
        end
        check("ovf_count", 32'(ld_count), 32'h100);
        check("ovf_err", 32'(ld_err), 32'd1);
        check("ovf_cpu_enable", 32'(cpu_enable), 32'd0);
        read_mem(8'h00, 16'h003C, "ovf_mem0");
        read_mem(8'hFF, 16'hFF3C, "ovf_mem255");

        // Reset while waiting for a low byte
        start_load();
        wait_ready();
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        send(8'h99, 1'b0);
        check("midload_count_before", 32'(ld_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midload_ready", 32'(ldif.ld_ready), 32'd0);
        check("midload_cpu_enable", 32'(cpu_enable), 32'd0);
        check("midload_count", 32'(ld_count), 32'd0);
        check("midload_busy", 32'(ld_busy), 32'd0);
        #2;
        reset = 1'b1;
        read_mem(8'h00, 16'h7788, "midload_partial_mem0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- 256x16 instruction memory that feeds the CPU fetch stage: takes the CPU's i_addr, returns i_datain.
- Contains a loader FSM. The loader clears memory, then fills it from a byte-serial valid/ready stream (host or UART bridge).
- Holds the CPU disabled through cpu_enable until a complete program has been written.
- Sits directly upstream of the CPU's IF stage.

Parameters:
AW, 8, address width; memory depth = 2^AW words.
DW, 16, instruction word width; must be 16 (two bytes per word).

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
i_addr  in  AW  CPU fetch address (pc)
i_datain  out  DW  instruction word to CPU, combinational read of mem[i_addr]
ld_start  in  1  one-cycle pulse that begins a clear+load sequence
ld_valid  in  1  ld_byte is valid
ld_byte  in  8  program byte, high byte of each word first
ld_last  in  1  qualifies the final byte of the program
ld_ready  out  1  loader accepts ld_byte this cycle
cpu_enable  out  1  drives CPU enable; 1 only when a valid program is resident
ld_busy  out  1  loader is in CLEAR or RECV states
ld_count  out  AW+1  number of words written in current/last load
ld_err  out  1  sticky error for the current/last load

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; cpu_enable=0, ld_ready=0, ld_busy=0, ld_count=0, ld_err=0.
  - Internal clear/write address=0; held high byte=0.
  - Memory contents are NOT reset.
  - A reset mid-load abandons the load; partial contents remain; cpu_enable stays 0.
- Read port:
  - i_datain = mem[i_addr] combinationally, zero-latency. The CPU samples it at the same edge that advances pc.
  - While ld_busy=1, i_datain is forced to 16'h0000 (a bubble word).
- FSM states: IDLE, CLEAR, RECV_HI, RECV_LO, DONE.
  - IDLE: ld_ready=0. ld_start=1 -> CLEAR; cpu_enable<=0, ld_count<=0, ld_err<=0, clear address<=0.
  - CLEAR: writes 16'h0000 to mem[clear address] each cycle, address+1. After writing address 2^AW-1 -> RECV_HI; takes exactly 2^AW cycles. ld_ready=0.
  - RECV_HI: ld_ready=1.
    - On ld_valid&ld_ready: latch ld_byte as high byte.
    - If ld_last=1 also: ld_err<=1, byte discarded, -> DONE (odd byte count).
    - Else -> RECV_LO.
  - RECV_LO: ld_ready=1.
    - On handshake: write {hi,ld_byte} to mem[ld_count[AW-1:0]] at that edge; ld_count<=ld_count+1.
    - If ld_last=1 -> DONE; else -> RECV_HI.
  - Overflow: when ld_count==2^AW, further words are not written. ld_err<=1 (sticky), ld_count saturates at 2^AW. Bytes are still accepted until ld_last.
  - DONE: ld_ready=0; cpu_enable<=1 iff ld_err==0. ld_start=1 -> CLEAR, with the same clears as from IDLE. Otherwise hold.
- ld_busy=1 in CLEAR, RECV_HI, RECV_LO; 0 otherwise.
- ld_start while ld_busy=1 is ignored.
- ld_valid outside RECV_* is ignored; no byte is consumed (ld_ready=0).
- A handshake is ld_valid & ld_ready at a rising edge. At most one byte per cycle; back-to-back bytes are allowed every cycle.
- cpu_enable changes only on the DONE entry edge, on ld_start acceptance, or on reset. Dropping it on ld_start stops the CPU before CLEAR overwrites memory.
- ld_count is stable and readable in DONE and IDLE.

Test Plan:
- Reset then idle:
  - Pulse reset low mid-cycle -> all outputs 0 immediately (async).
  - i_addr=8'h05 -> i_datain equals pre-existing mem[5]; cpu_enable stays 0 with no ld_start.
- Clear timing:
  - ld_start -> ld_busy=1 and ld_ready=0 for exactly 256 cycles, then ld_ready=1.
  - i_datain=0 throughout.
  - After a later load of 1 word, mem[1..255]=0.
- Normal load:
  - After clear, stream bytes 8'h12,8'h34,8'hAB,8'hCD (last on 8'hCD) with ld_valid gaps inserted.
  - -> mem[0]=16'h1234, mem[1]=16'hABCD, ld_count=2, ld_err=0, DONE, cpu_enable=1.
  - i_addr=1 -> i_datain=16'hABCD.
- Odd byte count:
  - Stream 8'h12,8'h34,8'h56 with last on 8'h56 -> mem[0]=16'h1234, ld_count=1, ld_err=1, cpu_enable=0.
- Overflow:
  - Stream 257 words (514 bytes), last on the final byte -> ld_count=256, ld_err=1.
  - mem[0] holds word 0, not word 256; cpu_enable=0.
- Reload and mid-load reset:
  - From DONE with cpu_enable=1, pulse ld_start -> cpu_enable=0 on the next edge, CLEAR entered.
  - Assert reset during RECV_LO -> IDLE, ld_ready=0, cpu_enable=0, ld_count=0.
